char_receiver: RTL and testbench

CHAR_RECEIVER -- requirements
Module: char_receiver

---
 rtl/char_receiver_pkg.sv | 21 ++
 rtl/char_fifo.sv | 111 +++++++++++
 rtl/char_receiver.sv | 194 +++++++++++++++++++
 tb/tb_char_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/char_receiver_pkg.sv
// Shared types and constants for the char_receiver UART block: FSM state
// encoding, oversampling factor and the baud-tick divisor helper.
package char_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  // Clocks per oversample tick; integer division truncates toward a slightly fast tick.
  function automatic int unsigned tick_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Receive buffer for char_receiver: first-word fall-through, head reads 0 when empty.
// CHAR_RECEIVER_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single holding register.
module char_fifo
  import char_receiver_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overrun_o
);

  logic do_rd;
  logic do_wr;
  logic overrun_q;
  logic overrun_d;

  // A pop in the same cycle frees the slot, so only an unaccompanied write while full drops.
  assign overrun_d = wr_en_i & full_o & ~rd_en_i;
  assign overrun_o = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

`ifdef CHAR_RECEIVER_FIFO_EN
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic       valid_q;
  logic       valid_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       unused_depth;

  assign unused_depth = (DEPTH != 0);

  assign empty_o = ~valid_q;
  assign full_o  = valid_q;

  assign do_rd = rd_en_i & valid_q;
  assign do_wr = wr_en_i & (~valid_q | do_rd);

  always_comb begin
    valid_d = valid_q;
    hold_d  = hold_q;
    if (do_wr) begin
      valid_d = 1'b1;
      hold_d  = wr_data_i;
    end else if (do_rd) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign rd_data_o = valid_q ? hold_q : 8'h00;
`endif

endmodule

// File: rtl/char_receiver.sv
// UART 8N1 receiver with 16x oversampling, centre sampling and a receive buffer.
// Define CHAR_RECEIVER_FIFO_EN for a FIFO_DEPTH-entry FIFO; default is one holding register.
module char_receiver
  import char_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  input  logic       rd_en,
  output logic [6:0] rd_ascii,
  output logic       rd_lang,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  output logic [3:0] num3,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0
);

  localparam int unsigned DIV_RAW = tick_divisor(CLK_HZ, BAUD);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SMP_MID  = 4'(OVERSAMPLE / 2 - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             rx_prev_q;
  logic             rx_s;
  logic             rx_fall;
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;

  rx_state_e  state_q;
  rx_state_e  state_d;
  logic [3:0] s_cnt_q;
  logic [3:0] s_cnt_d;
  logic [2:0] bit_cnt_q;
  logic [2:0] bit_cnt_d;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic       frame_err_q;
  logic       frame_err_d;
  logic [7:0] last_good_q;
  logic [7:0] last_good_d;
  logic       byte_done;
  logic [7:0] head_byte;

  // Synchronizer and edge-history flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= RsRx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;

  assign tick = (tick_cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        // Half a bit in: a line that has gone high again was only a glitch.
        if (tick) begin
          if (s_cnt_q == SMP_MID) begin
            s_cnt_d   = '0;
            bit_cnt_d = '0;
            state_d   = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_cnt_q == SMP_LAST) begin
            s_cnt_d   = '0;
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_cnt_q == SMP_LAST) begin
            s_cnt_d = '0;
            if (rx_s) begin
              byte_done = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Display copy follows every good byte, including ones the buffer drops.
  assign last_good_d = byte_done ? shift_q : last_good_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_cnt_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      last_good_q <= '0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      last_good_q <= last_good_d;
    end
  end

  char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (byte_done),
    .wr_data_i(shift_q),
    .rd_en_i  (rd_en),
    .rd_data_o(head_byte),
    .empty_o  (empty),
    .full_o   (full),
    .overrun_o(overrun)
  );

  assign rd_ascii  = head_byte[6:0];
  assign rd_lang   = head_byte[7];
  assign frame_err = frame_err_q;
  assign num3      = last_good_q[7:4];
  assign num2      = last_good_q[3:0];
  assign num1      = head_byte[7:4];
  assign num0      = head_byte[3:0];

endmodule

// File: tb/tb_char_receiver.sv
// Directed self-checking bench for char_receiver; clock scaled so one bit is 64 clocks.
`timescale 1ns/1ps
module tb_char_receiver;
  import char_receiver_pkg::*;

  localparam int unsigned BAUD     = 9600;
  localparam int unsigned CLK_HZ   = BAUD * 16 * 4;
  localparam int          BIT_CLKS = 64;
`ifdef CHAR_RECEIVER_FIFO_EN
  localparam int DEPTH_EFF = 8;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RsRx = 1'b1;
  logic       rd_en = 1'b0;
  logic [6:0] rd_ascii;
  logic       rd_lang;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;
  logic [3:0] num3, num2, num1, num0;

  int checks = 0;
  int failures = 0;
  int fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  int base_fp, base_fc, base_op, base_oc;

  char_receiver #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RsRx     (RsRx),
    .rd_en    (rd_en),
    .rd_ascii (rd_ascii),
    .rd_lang  (rd_lang),
    .empty    (empty),
    .full     (full),
    .frame_err(frame_err),
    .overrun  (overrun),
    .num3     (num3),
    .num2     (num2),
    .num1     (num1),
    .num0     (num0)
  );

  always #5 clk = ~clk;

  // Pulse monitors: rising edges and high cycles, so width errors show up.
  always @(negedge clk) begin
    if (frame_err) fe_cycles++;
    if (frame_err && !fe_prev) fe_pulses++;
    if (overrun) ov_cycles++;
    if (overrun && !ov_prev) ov_pulses++;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] b);
    RsRx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b);
    RsRx = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  task automatic snap();
    base_fp = fe_pulses;
    base_fc = fe_cycles;
    base_op = ov_pulses;
    base_oc = ov_cycles;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_ascii"}, rd_ascii, 7'h00);
    chk({tag, "_lang"}, rd_lang, 1'b0);
    chk({tag, "_nums"}, {num3, num2, num1, num0}, 16'h0000);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_state"}, dut.state_q, ST_IDLE);
  endtask

  initial begin
    logic [7:0] b7e;
    b7e = 8'h7E;

    // Power-on reset
    wait_clks(3);
    check_reset_values("por");
    rst_n = 1'b1;
    wait_clks(10);

    // 0x41: empty must fall shortly after the stop-bit centre, not before
    send_head(8'h41);
    RsRx = 1'b1;
    wait_clks(26);
    chk("a41_empty_before_stop_sample", empty, 1'b1);
    wait_clks(14);
    chk("a41_empty_after_stop_sample", empty, 1'b0);
    wait_clks(BIT_CLKS - 40);
    chk("a41_ascii", rd_ascii, 7'h41);
    chk("a41_lang", rd_lang, 1'b0);
    chk("a41_num32", {num3, num2}, 8'h41);
    chk("a41_num10", {num1, num0}, 8'h41);
    chk("a41_full", full, (DEPTH_EFF == 1));
    pop();
    chk("a41_pop_empty", empty, 1'b1);
    chk("a41_pop_num10", {num1, num0}, 8'h00);

    // 0xC1: language bit from bit 7
    send_byte(8'hC1);
    chk("c1_lang", rd_lang, 1'b1);
    chk("c1_ascii", rd_ascii, 7'h41);
    chk("c1_num10", {num1, num0}, 8'hC1);
    pop();
    chk("c1_pop_empty", empty, 1'b1);
    chk("c1_pop_num10", {num1, num0}, 8'h00);
    chk("c1_num32", {num3, num2}, 8'hC1);

    // rd_en while empty is ignored
    pop();
    chk("rd_empty_empty", empty, 1'b1);
    chk("rd_empty_full", full, 1'b0);

    // 5-tick low glitch
    snap();
    RsRx = 1'b0;
    wait_clks(20);
    RsRx = 1'b1;
    wait_clks(100);
    chk("glitch_empty", empty, 1'b1);
    chk("glitch_frame_err", fe_pulses - base_fp, 0);
    chk("glitch_state", dut.state_q, ST_IDLE);

    // 0x55 with a bad stop bit, then 0x33
    snap();
    send_head(8'h55);
    RsRx = 1'b0;
    wait_clks(BIT_CLKS + 20);
    RsRx = 1'b1;
    wait_clks(10);
    chk("ferr_pulses", fe_pulses - base_fp, 1);
    chk("ferr_width", fe_cycles - base_fc, 1);
    chk("ferr_empty", empty, 1'b1);
    chk("ferr_num32", {num3, num2}, 8'hC1);
    wait_clks(BIT_CLKS);
    send_byte(8'h33);
    chk("after_ferr_empty", empty, 1'b0);
    chk("after_ferr_ascii", rd_ascii, 7'h33);
    chk("after_ferr_num32", {num3, num2}, 8'h33);
    pop();
    chk("after_ferr_pop_empty", empty, 1'b1);

    // Nine bytes without reads: fill, then overrun on every extra byte
    snap();
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h30 + 8'(i));
      if (i == DEPTH_EFF - 2) chk("fill_not_full", full, 1'b0);
      if (i == DEPTH_EFF - 1) chk("fill_full", full, 1'b1);
    end
    chk("fill_overrun_pulses", ov_pulses - base_op, 9 - DEPTH_EFF);
    chk("fill_overrun_width", ov_cycles - base_oc, 9 - DEPTH_EFF);
    chk("fill_num32", {num3, num2}, 8'h38);
    for (int j = 0; j < DEPTH_EFF; j++) begin
      chk("fill_read_head", {rd_lang, rd_ascii}, 8'h30 + 8'(j));
      pop();
    end
    chk("fill_drained_empty", empty, 1'b1);
    chk("fill_drained_full", full, 1'b0);

    // Reset in the middle of 0x7E with a byte already buffered
    send_byte(8'h5A);
    chk("pre_rst_empty", empty, 1'b0);
    RsRx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      RsRx = b7e[i];
      wait_clks(BIT_CLKS);
    end
    RsRx = b7e[3];
    wait_clks(10);
    rst_n = 1'b0;
    wait_clks(3);
    check_reset_values("mid_rst");
    wait_clks(BIT_CLKS - 13);
    for (int i = 4; i < 8; i++) begin
      RsRx = b7e[i];
      wait_clks(BIT_CLKS);
    end
    RsRx = 1'b1;
    wait_clks(BIT_CLKS + 20);
    rst_n = 1'b1;
    wait_clks(20);
    chk("post_rst_empty", empty, 1'b1);
    send_byte(8'h21);
    chk("post_rst_ascii", rd_ascii, 7'h21);
    chk("post_rst_lang", rd_lang, 1'b0);
    chk("post_rst_num32", {num3, num2}, 8'h21);
    chk("post_rst_empty_after_frame", empty, 1'b0);
    pop();
    chk("post_rst_pop_empty", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
